// File: rtl/fix_div_if.sv
// Start/done handshake and operand/result bus of the fixed-point divider.
// master drives the request, slave (the divider) returns the status and quotient.
interface fix_div_if #(
    parameter int WIDTH = 37
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, a, b,
        input  busy, done, result, div_by_zero, overflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, result, div_by_zero, overflow
    );
endinterface

// File: rtl/fix_div.sv
// Restoring fixed-point divider, one quotient bit per cycle: done pulses WIDTH cycles after start is taken.
// No queueing: start is only sampled in IDLE; start while busy is dropped, result held until the next done.
module fix_div #(
    parameter int WIDTH = 37
) (
    input  logic      clk,
    input  logic      reset,
    fix_div_if.slave  bus
);
    localparam int FRAC_BITS = WIDTH - 2;
    localparam int N         = FRAC_BITS + 1;
    localparam int CW        = $clog2(N + 1);

    localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_MAX = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem;
    logic [N-1:0]     quo;
    logic             feed;
    logic [CW-1:0]    cnt;
    logic             sign;
    logic             a_neg;
    logic             a_zero;
    logic             dz;
    logic             ovf;

    logic [WIDTH-1:0] a_mag_in;
    logic [WIDTH-1:0] b_mag_in;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] quo_ext;

    // Unsigned magnitudes: -2.0 maps to 2^(WIDTH-1), which still fits.
    assign a_mag_in = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign b_mag_in = bus.b[WIDTH-1] ? -bus.b : bus.b;

    // Remainder starts at |a|>>1; |a|[0] then zeros are brought down, i.e. |a|*2^FRAC_BITS.
    assign shifted  = {rem[WIDTH-1:0], feed};
    assign diff     = shifted - {1'b0, b_mag};
    assign quo_ext  = {1'b0, quo};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.result      <= '0;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
            b_mag           <= '0;
            rem             <= '0;
            quo             <= '0;
            feed            <= 1'b0;
            cnt             <= '0;
            sign            <= 1'b0;
            a_neg           <= 1'b0;
            a_zero          <= 1'b0;
            dz              <= 1'b0;
            ovf             <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        b_mag    <= b_mag_in;
                        rem      <= {2'b00, a_mag_in[WIDTH-1:1]};
                        feed     <= a_mag_in[0];
                        quo      <= '0;
                        cnt      <= CW'(N);
                        sign     <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        a_neg    <= bus.a[WIDTH-1];
                        a_zero   <= (bus.a == '0);
                        dz       <= (bus.b == '0);
                        ovf      <= (bus.b != '0) && ({1'b0, a_mag_in} >= {b_mag_in, 1'b0});
                        bus.busy <= 1'b1;
                        state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    rem  <= diff[WIDTH] ? shifted : diff;
                    quo  <= {quo[N-2:0], ~diff[WIDTH]};
                    feed <= 1'b0;
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= S_DONE;
                end
                S_DONE: begin
                    bus.done        <= 1'b1;
                    bus.busy        <= 1'b0;
                    bus.div_by_zero <= dz;
                    bus.overflow    <= ovf;
                    if (dz)
                        bus.result <= a_zero ? '0 : (a_neg ? NEG_MAX : POS_MAX);
                    else if (ovf)
                        bus.result <= sign ? NEG_MAX : POS_MAX;
                    else
                        bus.result <= sign ? -quo_ext : quo_ext;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
